jk_bank_arbiter: RTL and testbench

Round-robin arbiter and command sequencer for a bank of JK flip-flop bits shared by several requesters. Each requester asks for one JK operation (hold, clear, set, toggle) on one bit of the bank. The block grants one requester per clock and applies that requester's operation to the addressed bit. It sits between control agents and the shared flag/status register they all update.

---
 rtl/jk_bank_arbiter.sv | 152 +++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// ---------------------------------------------------------------------------
// jk_bank_arbiter
//
// Round-robin arbiter and command sequencer for a shared bank of JK
// flip-flop bits. Each requester asks for one JK operation (hold, clear,
// set, toggle) on one bit of the bank. One requester is granted per clock,
// and its operation is applied to the addressed bit at the same edge that
// issues the grant.
//
// Parameters:
//   NREQ  - number of requesters (2..8)
//   WIDTH - number of JK bits in the bank (2..32)
//   IDXW  - bit-index width, 2**IDXW >= WIDTH
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   req      in   [NREQ]        per-requester request level
//   jk       in   [2*NREQ]      per-requester {j,k}; requester i at [2i+1:2i]
//   idx      in   [NREQ*IDXW]   per-requester target bit index, slice i
//   clr_all  in   clear the whole bank (wins over every request)
//   gnt      out  [NREQ]        registered one-hot grant pulse
//   q        out  [WIDTH]       JK bank state
//   err      out  pulse: granted index was out of range
// ---------------------------------------------------------------------------
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [2*NREQ-1:0]      jk,
  input  logic [NREQ*IDXW-1:0]   idx,
  input  logic                   clr_all,
  output logic [NREQ-1:0]        gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   err
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_CLR  = 2'b01,
    OP_SET  = 2'b10,
    OP_TGL  = 2'b11
  } jk_op_e;

  // Registered state
  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_q;
  logic             r_err;
  logic [PTRW-1:0]  r_ptr;

  // Combinational decision for the coming edge
  logic [NREQ-1:0]  w_elig;
  logic             w_win_vld;
  logic [PTRW-1:0]  w_win;
  logic [PTRW-1:0]  w_ptr_nxt;
  logic [IDXW-1:0]  w_tgt;
  jk_op_e           w_op;
  logic             w_oor;
  logic [NREQ-1:0]  w_gnt_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // (base + off) mod NREQ without a divider; off never exceeds NREQ.
  function automatic logic [PTRW-1:0] wrap_add(input logic [PTRW-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = int'(base) + off;
    if (s >= unsigned'(NREQ)) s = s - unsigned'(NREQ);
    return s[PTRW-1:0];
  endfunction

  // A requester granted in the current cycle sits out this cycle, so a
  // requester that keeps req high after its grant is seen as a new request.
  assign w_elig = req & ~r_gnt;

  // Rotating priority search starting at r_ptr. The loop walks from the
  // farthest candidate back to r_ptr so the nearest eligible one is written
  // last and wins.
  // NOTE: every always_comb output gets a default first; a path that leaves
  // a signal unassigned would infer a latch.
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_elig[wrap_add(r_ptr, k)]) begin
        w_win_vld = 1'b1;
        w_win     = wrap_add(r_ptr, k);
      end
    end
  end

  // Winner's operation and target
  assign w_ptr_nxt = wrap_add(w_win, 1);
  assign w_tgt     = idx[int'(w_win)*IDXW +: IDXW];
  assign w_op      = jk_op_e'(jk[2*int'(w_win) +: 2]);
  assign w_oor     = (int'(w_tgt) >= WIDTH);

  always_comb begin
    w_gnt_nxt = '0;
    if (w_win_vld) w_gnt_nxt[w_win] = 1'b1;
  end

  // Only the addressed bit can change; an out-of-range index matches no bit,
  // so the whole bank holds.
  always_comb begin
    w_q_nxt = r_q;
    if (w_win_vld) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (int'(w_tgt) == b) begin
          case (w_op)
            OP_CLR:  w_q_nxt[b] = 1'b0;
            OP_SET:  w_q_nxt[b] = 1'b1;
            OP_TGL:  w_q_nxt[b] = ~r_q[b];
            default: w_q_nxt[b] = r_q[b];
          endcase
        end
      end
    end
  end

  // Priority: rst, then clr_all, then normal arbitration. clr_all leaves the
  // pointer alone and issues no grant, so pending requests are served later.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt <= '0;
      r_q   <= '0;
      r_err <= 1'b0;
      r_ptr <= '0;
    end else if (clr_all) begin
      r_gnt <= '0;
      r_q   <= '0;
      r_err <= 1'b0;
    end else begin
      r_gnt <= w_gnt_nxt;
      r_q   <= w_q_nxt;
      r_err <= w_win_vld & w_oor;
      if (w_win_vld) r_ptr <= w_ptr_nxt;
    end
  end

  assign gnt = r_gnt;
  assign q   = r_q;
  assign err = r_err;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_jk_bank_arbiter
//
// Instance A: NREQ=4, WIDTH=8, IDXW=3 (table of directed vectors plus a
//             hand-written fill-then-clear collision sequence).
// Instance B: NREQ=4, WIDTH=6, IDXW=3 (out-of-range index handling).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_jk_bank_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_rst, a_clr;
  logic [3:0]  a_req;
  logic [7:0]  a_jk;
  logic [11:0] a_idx;
  logic [3:0]  a_gnt;
  logic [7:0]  a_q;
  logic        a_err;

  // Instance B signals
  logic        b_rst, b_clr;
  logic [3:0]  b_req;
  logic [7:0]  b_jk;
  logic [11:0] b_idx;
  logic [3:0]  b_gnt;
  logic [5:0]  b_q;
  logic        b_err;

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8), .IDXW(3)) u_dut_a (
    .clk     (clk),
    .rst     (a_rst),
    .req     (a_req),
    .jk      (a_jk),
    .idx     (a_idx),
    .clr_all (a_clr),
    .gnt     (a_gnt),
    .q       (a_q),
    .err     (a_err)
  );

  jk_bank_arbiter #(.NREQ(4), .WIDTH(6), .IDXW(3)) u_dut_b (
    .clk     (clk),
    .rst     (b_rst),
    .req     (b_req),
    .jk      (b_jk),
    .idx     (b_idx),
    .clr_all (b_clr),
    .gnt     (b_gnt),
    .q       (b_q),
    .err     (b_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic rst, input logic clr, input logic [3:0] req,
                        input logic [7:0] jk, input logic [11:0] idx);
    @(negedge clk);
    a_rst = rst; a_clr = clr; a_req = req; a_jk = jk; a_idx = idx;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic rst, input logic [3:0] req,
                        input logic [7:0] jk, input logic [11:0] idx);
    @(negedge clk);
    b_rst = rst; b_clr = 1'b0; b_req = req; b_jk = jk; b_idx = idx;
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] gnt,
                         input logic [7:0] q, input logic err);
    check({tag, " gnt"}, 32'(a_gnt), 32'(gnt));
    check({tag, " q"},   32'(a_q),   32'(q));
    check({tag, " err"}, 32'(a_err), 32'(err));
  endtask

  task automatic check_b(input string tag, input logic [3:0] gnt,
                         input logic [5:0] q, input logic err);
    check({tag, " gnt"}, 32'(b_gnt), 32'(gnt));
    check({tag, " q"},   32'(b_q),   32'(q));
    check({tag, " err"}, 32'(b_err), 32'(err));
  endtask

  typedef struct packed {
    logic        rst;
    logic        clr;
    logic [3:0]  req;
    logic [7:0]  jk;
    logic [11:0] idx;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        err;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  initial begin
    logic [11:0] fill_idx;

    a_rst = 1'b1; a_clr = 1'b0; a_req = '0; a_jk = '0; a_idx = '0;
    b_rst = 1'b1; b_clr = 1'b0; b_req = '0; b_jk = '0; b_idx = '0;

    // {rst, clr, req, jk, idx, exp gnt, exp q, exp err}
    // idx 12'h688 puts index i in requester i's slice; jk 8'hFF = all toggle.
    vecs[0]  = '{1'b1, 1'b0, 4'hF, 8'hFF, 12'h688, 4'h0, 8'h00, 1'b0}; // reset, all requesting
    vecs[1]  = '{1'b1, 1'b0, 4'hF, 8'hFF, 12'h688, 4'h0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'hF, 8'hFF, 12'h688, 4'h1, 8'h01, 1'b0}; // first grant to 0
    vecs[3]  = '{1'b0, 1'b0, 4'hF, 8'hFF, 12'h688, 4'h2, 8'h03, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'hF, 8'hFF, 12'h688, 4'h4, 8'h07, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'hF, 8'hFF, 12'h688, 4'h8, 8'h0F, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'hF, 8'hFF, 12'h688, 4'h1, 8'h0E, 1'b0}; // wraps to 0, ptr=1
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 8'h00, 12'h000, 4'h0, 8'h0E, 1'b0}; // idle
    vecs[8]  = '{1'b0, 1'b1, 4'h0, 8'h00, 12'h000, 4'h0, 8'h00, 1'b0}; // clr_all
    vecs[9]  = '{1'b0, 1'b0, 4'h4, 8'h20, 12'h140, 4'h4, 8'h20, 1'b0}; // r2 set bit5, ptr=3
    vecs[10] = '{1'b0, 1'b0, 4'h4, 8'h30, 12'h140, 4'h0, 8'h20, 1'b0}; // r2 masked
    vecs[11] = '{1'b0, 1'b0, 4'h4, 8'h30, 12'h140, 4'h4, 8'h00, 1'b0}; // r2 toggle bit5
    vecs[12] = '{1'b0, 1'b0, 4'h0, 8'h00, 12'h000, 4'h0, 8'h00, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 4'h2, 8'h08, 12'h000, 4'h2, 8'h01, 1'b0}; // r1 alone, ptr=2
    vecs[14] = '{1'b0, 1'b0, 4'h2, 8'h08, 12'h000, 4'h0, 8'h01, 1'b0}; // masked
    vecs[15] = '{1'b0, 1'b0, 4'h2, 8'h08, 12'h000, 4'h2, 8'h01, 1'b0}; // ptr=2
    vecs[16] = '{1'b0, 1'b0, 4'hC, 8'hF0, 12'hF80, 4'h4, 8'h41, 1'b0}; // r2 beats r3
    vecs[17] = '{1'b0, 1'b0, 4'hC, 8'hF0, 12'hF80, 4'h8, 8'hC1, 1'b0}; // then r3, ptr=0
    vecs[18] = '{1'b0, 1'b0, 4'hC, 8'hF0, 12'hF80, 4'h4, 8'h81, 1'b0}; // r2 again
    vecs[19] = '{1'b1, 1'b0, 4'hF, 8'hFF, 12'h688, 4'h0, 8'h00, 1'b0}; // mid-stream reset
    vecs[20] = '{1'b0, 1'b0, 4'hF, 8'hFF, 12'h688, 4'h1, 8'h01, 1'b0}; // ptr back at 0
    vecs[21] = '{1'b0, 1'b1, 4'hF, 8'hFF, 12'h688, 4'h0, 8'h00, 1'b0}; // clr_all beats req
    vecs[22] = '{1'b0, 1'b0, 4'hF, 8'hFF, 12'h688, 4'h2, 8'h02, 1'b0}; // ptr kept at 1

    for (int i = 0; i < NVEC; i++) begin
      step_a(vecs[i].rst, vecs[i].clr, vecs[i].req, vecs[i].jk, vecs[i].idx);
      check_a($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].q, vecs[i].err);
    end

    // Fill the bank to 0xFF with requesters 0 and 1 setting bits in turn.
    // With only two requesters the mask forces strict alternation 0,1,0,1.
    step_a(1'b0, 1'b0, 4'h0, 8'h00, 12'h000);
    check_a("fill idle", 4'h0, 8'h02, 1'b0);
    for (int c = 0; c < 8; c++) begin
      fill_idx      = '0;
      fill_idx[2:0] = 3'((c / 2) * 2);
      fill_idx[5:3] = 3'((c / 2) * 2 + 1);
      step_a(1'b0, 1'b0, 4'h3, 8'h0A, fill_idx);
      check($sformatf("fill%0d gnt", c), 32'(a_gnt), (c % 2 == 0) ? 32'h1 : 32'h2);
    end
    check("fill q", 32'(a_q), 32'hFF);

    // clr_all collides with a clear request on bit 0
    step_a(1'b0, 1'b0, 4'h0, 8'h00, 12'h000);
    check_a("coll idle", 4'h0, 8'hFF, 1'b0);
    step_a(1'b0, 1'b1, 4'h1, 8'h01, 12'h000);
    check_a("coll clr", 4'h0, 8'h00, 1'b0);
    step_a(1'b0, 1'b0, 4'h1, 8'h01, 12'h000);
    check_a("coll pending", 4'h1, 8'h00, 1'b0);
    step_a(1'b0, 1'b0, 4'h0, 8'h00, 12'h000);

    // Instance B: WIDTH=6, indices 6 and 7 are out of range
    step_b(1'b1, 4'hF, 8'hFF, 12'h000);
    check_b("b reset", 4'h0, 6'h00, 1'b0);
    step_b(1'b0, 4'h1, 8'h02, 12'h005);
    check_b("b set5", 4'h1, 6'h20, 1'b0);
    step_b(1'b0, 4'h0, 8'h00, 12'h000);
    check_b("b idle", 4'h0, 6'h20, 1'b0);
    step_b(1'b0, 4'h1, 8'h02, 12'h007);
    check_b("b oor7", 4'h1, 6'h20, 1'b1);
    step_b(1'b0, 4'h0, 8'h00, 12'h000);
    check_b("b err drop", 4'h0, 6'h20, 1'b0);
    step_b(1'b0, 4'h1, 8'h03, 12'h006);
    check_b("b oor6", 4'h1, 6'h20, 1'b1);
    // ptr advanced past 0 even on an out-of-range grant: r1 beats r0
    step_b(1'b0, 4'h3, 8'h0F, 12'h000);
    check_b("b ptr", 4'h2, 6'h21, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
